// File: rtl/stopwatch_cmd_sched.sv
// Front-panel command scheduler: turns button levels into single command tokens,
// arbitrates by fixed priority and adds hold-to-repeat tokens for Up/Down.
module stopwatch_cmd_sched #(
  parameter int DELAY_CYCLES  = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Btn,
  input  logic       CmdReady,
  output logic       CmdValid,
  output logic [1:0] CmdCode,
  output logic       CmdRepeat,
  output logic       RptActive
);

  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         btn_q_reg;
  logic [3:0]         pending_reg, pending_next;
  logic [3:0]         rpt_flag_reg, rpt_flag_next;
  logic               valid_reg, valid_next;
  logic [1:0]         code_reg, code_next;
  logic               repeat_reg, repeat_next;
  logic [1:0]         rpt_idx_reg, rpt_idx_next;
  logic [CNT_W-1:0]   timer_reg, timer_next;

  logic [3:0]         rise;
  logic [3:0]         clr_mask;
  logic [3:0]         set_mask;
  logic [3:0]         flag_set;
  logic [3:0]         pending_kept;
  logic               out_free;
  logic               grant;
  logic [1:0]         grant_idx;
  logic               expire;

  assign rise     = Btn & ~btn_q_reg;
  assign out_free = !valid_reg || CmdReady;
  assign grant    = out_free && (pending_reg != 4'b0000);

  // Lowest pending index wins: Clear > StartStop > Up > Down.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_reg[i]) begin
        grant_idx = 2'(i);
      end
    end
  end

  // Output register and repeat tracker next state.
  always_comb begin
    state_next   = state_reg;
    rpt_idx_next = rpt_idx_reg;
    timer_next   = timer_reg;
    valid_next   = valid_reg;
    code_next    = code_reg;
    repeat_next  = repeat_reg;
    clr_mask     = 4'b0000;
    expire       = 1'b0;

    if (out_free) begin
      valid_next = grant;
      if (grant) begin
        code_next   = grant_idx;
        repeat_next = rpt_flag_reg[grant_idx];
        clr_mask[grant_idx] = 1'b1;
      end
    end

    if (grant && (grant_idx == 2'd0)) begin
      // Clear cancels any Up/Down activity, including queued presses.
      state_next    = IDLE;
      timer_next    = '0;
      clr_mask[3:2] = 2'b11;
    end else if (grant && grant_idx[1] && !rpt_flag_reg[grant_idx]) begin
      rpt_idx_next = grant_idx;
      timer_next   = DELAY_LOAD;
      state_next   = DELAY;
    end else if (state_reg != IDLE) begin
      if (!Btn[rpt_idx_reg]) begin
        state_next = IDLE;
        timer_next = '0;
      end else if (timer_reg == '0) begin
        expire     = 1'b1;
        timer_next = REPEAT_LOAD;
        state_next = REPEAT;
      end else begin
        timer_next = timer_reg - CNT_W'(1);
      end
    end
  end

  // A repeat that finds its button still queued is merged, so stalls never pile up.
  always_comb begin
    pending_kept = pending_reg & ~clr_mask;
    flag_set     = 4'b0000;
    if (expire && !pending_kept[rpt_idx_reg]) begin
      flag_set[rpt_idx_reg] = 1'b1;
    end
    set_mask = rise | flag_set;
  end

  // Per-button bookkeeping: a set always beats a clear on the same bit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      assign pending_next[gi]  = set_mask[gi] | pending_kept[gi];
      assign rpt_flag_next[gi] = (rpt_flag_reg[gi] | flag_set[gi]) & ~rise[gi];
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= IDLE;
      btn_q_reg    <= 4'b1111;
      pending_reg  <= 4'b0000;
      rpt_flag_reg <= 4'b0000;
      valid_reg    <= 1'b0;
      code_reg     <= 2'd0;
      repeat_reg   <= 1'b0;
      rpt_idx_reg  <= 2'd0;
      timer_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      btn_q_reg    <= Btn;
      pending_reg  <= pending_next;
      rpt_flag_reg <= rpt_flag_next;
      valid_reg    <= valid_next;
      code_reg     <= code_next;
      repeat_reg   <= repeat_next;
      rpt_idx_reg  <= rpt_idx_next;
      timer_reg    <= timer_next;
    end
  end

  assign CmdValid  = valid_reg;
  assign CmdCode   = code_reg;
  assign CmdRepeat = repeat_reg;
  assign RptActive = (state_reg != IDLE);

endmodule

// File: tb/tb_stopwatch_cmd_sched.sv
// Bench for stopwatch_cmd_sched: a deadline-based behavioural model checked every
// cycle, plus hand-computed token timelines for each directed scenario.
module tb_stopwatch_cmd_sched;

  localparam int DLY = 8;
  localparam int RPT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       ready = 1'b1;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_repeat;
  logic       rpt_active;

  stopwatch_cmd_sched #(
    .DELAY_CYCLES (DLY),
    .REPEAT_CYCLES(RPT),
    .CNT_W        (4)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .Btn      (btn),
    .CmdReady (ready),
    .CmdValid (cmd_valid),
    .CmdCode  (cmd_code),
    .CmdRepeat(cmd_repeat),
    .RptActive(rpt_active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int code;
    int rep;
  } tok_t;
  tok_t log_q[$];

  // Model state: which buttons are queued, what is on the output, and when
  // the next repeat is due (absolute edge number).
  bit [3:0] m_prev;
  bit [3:0] m_pend;
  bit [3:0] m_flag;
  bit       m_valid;
  int       m_code;
  bit       m_rep;
  bit       m_active;
  int       m_idx;
  int       m_due;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_tok(input string name, input int idx, input int tcyc,
                         input int code, input int rep);
    total++;
    if (idx >= log_q.size()) begin
      bad++;
      $display("FAIL %s: token %0d missing (only %0d seen)", name, idx, log_q.size());
    end else if (log_q[idx].cyc != tcyc || log_q[idx].code != code || log_q[idx].rep != rep) begin
      bad++;
      $display("FAIL %s: got cyc=%0d code=%0d rep=%0d expected cyc=%0d code=%0d rep=%0d",
               name, log_q[idx].cyc, log_q[idx].code, log_q[idx].rep, tcyc, code, rep);
    end
  endtask

  task automatic model_reset();
    m_prev   = 4'b1111;
    m_pend   = 4'b0000;
    m_flag   = 4'b0000;
    m_valid  = 1'b0;
    m_code   = 0;
    m_rep    = 1'b0;
    m_active = 1'b0;
    m_idx    = 0;
    m_due    = 0;
  endtask

  task automatic model_step();
    bit [3:0] rise;
    int       g;
    bit       fire;
    rise = btn & ~m_prev;
    g = -1;
    if (!m_valid || ready) begin
      for (int i = 3; i >= 0; i--) if (m_pend[i]) g = i;
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_code    = g;
        m_rep     = m_flag[g];
        m_pend[g] = 1'b0;
      end
    end
    fire = 1'b0;
    if (g == 0) begin
      m_active    = 1'b0;
      m_pend[3:2] = 2'b00;
    end else if (g >= 2 && !m_rep) begin
      m_active = 1'b1;
      m_idx    = g;
      m_due    = cyc + DLY;
    end else if (m_active) begin
      if (!btn[m_idx]) m_active = 1'b0;
      else if (cyc == m_due) begin
        fire  = 1'b1;
        m_due = cyc + RPT;
      end
    end
    if (fire && !m_pend[m_idx]) begin
      m_pend[m_idx] = 1'b1;
      m_flag[m_idx] = 1'b1;
    end
    m_pend = m_pend | rise;
    m_flag = m_flag & ~rise;
    m_prev = btn;
  endtask

  // Advance n edges; inputs may change 2 ns after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else model_step();
    end
    #2;
  endtask

  // Per-cycle comparison against the model, and transfer logging.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valid", int'(cmd_valid), int'(m_valid));
        chk("code", int'(cmd_code), m_code);
        chk("repeat", int'(cmd_repeat), int'(m_rep));
        chk("rpt_active", int'(rpt_active), int'(m_active));
        if (cmd_valid && ready) begin
          log_q.push_back('{cyc: cyc, code: int'(cmd_code), rep: int'(cmd_repeat)});
          $display("token cyc=%0d code=%0d repeat=%0d", cyc, cmd_code, cmd_repeat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    model_reset();

    // 1: StartStop held through reset release, then re-pressed
    btn = 4'b0010;
    step(3);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_code", int'(cmd_code), 0);
    chk("reset_active", int'(rpt_active), 0);
    rst = 1'b0;
    step(5);
    btn = 4'b0000;
    step(2);
    chk("t1_no_token_held", log_q.size(), 0);
    c = cyc;
    btn = 4'b0010;
    step(6);
    btn = 4'b0000;
    step(2);
    chk("t1_count", log_q.size(), 1);
    chk_tok("t1_tok", 0, c + 2, 1, 0);

    // 2: StartStop and Down rise together
    log_q.delete();
    c = cyc;
    btn = 4'b1010;
    step(4);
    btn = 4'b0000;
    step(4);
    chk("t2_count", log_q.size(), 2);
    chk_tok("t2_first", 0, c + 2, 1, 0);
    chk_tok("t2_second", 1, c + 3, 3, 0);

    // 3: hold Up for 30 cycles
    log_q.delete();
    c = cyc;
    btn = 4'b0100;
    step(30);
    chk("t3_active_held", int'(rpt_active), 1);
    btn = 4'b0000;
    step(1);
    chk("t3_active_released", int'(rpt_active), 0);
    step(4);
    chk("t3_count", log_q.size(), 7);
    chk_tok("t3_edge", 0, c + 2, 2, 0);
    chk_tok("t3_rep1", 1, c + 11, 2, 1);
    chk_tok("t3_rep2", 2, c + 15, 2, 1);
    chk_tok("t3_rep_last", 6, c + 31, 2, 1);

    // 4: core stalled while Down is held
    log_q.delete();
    c = cyc;
    btn = 4'b1000;
    step(3);
    ready = 1'b0;
    step(12);
    chk("t4_stall_valid", int'(cmd_valid), 1);
    chk("t4_stall_code", int'(cmd_code), 3);
    chk("t4_stall_repeat", int'(cmd_repeat), 1);
    step(8);
    ready = 1'b1;
    btn = 4'b0000;
    step(4);
    chk("t4_count", log_q.size(), 3);
    chk_tok("t4_edge", 0, c + 2, 3, 0);
    chk_tok("t4_stalled", 1, c + 23, 3, 1);
    chk_tok("t4_merged", 2, c + 24, 3, 1);

    // 5: Clear pressed while Up is repeating
    log_q.delete();
    c = cyc;
    btn = 4'b0100;
    step(12);
    btn = 4'b0101;
    step(15);
    chk("t5_active_after_clear", int'(rpt_active), 0);
    btn = 4'b0000;
    step(3);
    chk("t5_count", log_q.size(), 3);
    chk_tok("t5_edge", 0, c + 2, 2, 0);
    chk_tok("t5_rep", 1, c + 11, 2, 1);
    chk_tok("t5_clear", 2, c + 14, 0, 0);

    // 6: reset during a stalled handshake
    log_q.delete();
    ready = 1'b0;
    btn = 4'b0100;
    step(4);
    chk("t6_pre_valid", int'(cmd_valid), 1);
    chk("t6_pre_active", int'(rpt_active), 1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_async_valid", int'(cmd_valid), 0);
    chk("t6_async_active", int'(rpt_active), 0);
    chk("t6_async_code", int'(cmd_code), 0);
    step(2);
    ready = 1'b1;
    rst = 1'b0;
    step(12);
    chk("t6_no_token_held", log_q.size(), 0);
    btn = 4'b0000;
    step(2);
    c = cyc;
    btn = 4'b0100;
    step(3);
    btn = 4'b0000;
    step(3);
    chk("t6_count", log_q.size(), 1);
    chk_tok("t6_fresh", 0, c + 2, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
